// File: rtl/core_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer_pkg
// Description : Shared types and helpers for the core instruction sequencer.
//               It defines the state encoding, the stage count and the
//               mapping from states to per-stage handshake lanes.
// Revision    : 1.0 - initial release
// ============================================================================
package core_sequencer_pkg;

  // Sequencer states. IDLE and HUNG are the only states that are not stages.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WRITE  = 3'd5,
    S_TRAP   = 3'd6,
    S_HUNG   = 3'd7
  } seq_state_t;

  // Number of stages that have an enabled/completed handshake.
  localparam int unsigned SEQ_STAGE_CNT = 6;

  // Bit position of each stage in the enable/completed lane vectors.
  localparam int unsigned STG_FETCH  = 0;
  localparam int unsigned STG_DECODE = 1;
  localparam int unsigned STG_EXEC   = 2;
  localparam int unsigned STG_MEM    = 3;
  localparam int unsigned STG_WRITE  = 4;
  localparam int unsigned STG_TRAP   = 5;

  // One-hot stage lane for a state; zero for IDLE and HUNG.
  function automatic logic [SEQ_STAGE_CNT-1:0] stage_onehot(input seq_state_t s);
    logic [SEQ_STAGE_CNT-1:0] oh;
    oh = '0;
    case (s)
      S_FETCH:  oh[STG_FETCH]  = 1'b1;
      S_DECODE: oh[STG_DECODE] = 1'b1;
      S_EXEC:   oh[STG_EXEC]   = 1'b1;
      S_MEM:    oh[STG_MEM]    = 1'b1;
      S_WRITE:  oh[STG_WRITE]  = 1'b1;
      S_TRAP:   oh[STG_TRAP]   = 1'b1;
      default:  oh = '0;
    endcase
    return oh;
  endfunction

  // True while the sequencer is waiting on a stage handshake.
  function automatic logic is_stage(input seq_state_t s);
    return (s != S_IDLE) && (s != S_HUNG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : seq_watchdog
// Description : Stage-hang watchdog. Counts cycles spent in the current
//               stage and flags the last permitted cycle so the sequencer
//               can escalate to the hung state if the stage still has not
//               completed.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_W      = 11
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  // Counter value during the final cycle a stage is allowed to occupy.
  localparam logic [TIMEOUT_W-1:0] C_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  // Clear on state change, otherwise count cycles while a stage is active.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The counter reads 0 in the first stage cycle, so C_LIMIT marks cycle
  // number TIMEOUT_CYCLES; a done in that same cycle still wins upstream.
  assign expired = run & (count_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle control FSM for the core. Steps each instruction
//               through fetch, decode, exec, (mem), write or trap using
//               one-cycle enable pulses and level completion inputs, honours
//               a sticky halt request, and traps stage hangs.
//               Optional feature macro: SEQ_PERF_CNT_EN enables the 64-bit
//               cycle and retired-instruction counters; without it both
//               counter outputs are constant zero.
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_W      = 11
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        halt_req,
  output logic        fetch_enabled,
  input  logic        fetch_completed,
  output logic        decode_enabled,
  input  logic        decode_completed,
  output logic        exec_enabled,
  input  logic        exec_completed,
  output logic        mem_enabled,
  input  logic        mem_completed,
  output logic        write_enabled,
  input  logic        write_completed,
  output logic        trap_enabled,
  input  logic        trap_completed,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_amo,
  input  logic        exception,
  output logic        busy,
  output logic        retired,
  output logic        hang_err,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  seq_state_t               state_q, state_d;
  logic [SEQ_STAGE_CNT-1:0] en_q, en_d;
  logic                     halt_q, halt_d;
  logic                     retired_q, retired_d;
  logic                     hang_q, hang_d;

  logic [SEQ_STAGE_CNT-1:0] w_completed;
  logic [SEQ_STAGE_CNT-1:0] w_cur_stage;
  logic                     w_first_cycle;
  logic                     w_done;
  logic                     w_is_mem;
  logic                     w_wd_run;
  logic                     w_wd_clear;
  logic                     w_wd_expired;

  assign w_completed[STG_FETCH]  = fetch_completed;
  assign w_completed[STG_DECODE] = decode_completed;
  assign w_completed[STG_EXEC]   = exec_completed;
  assign w_completed[STG_MEM]    = mem_completed;
  assign w_completed[STG_WRITE]  = write_completed;
  assign w_completed[STG_TRAP]   = trap_completed;

  // The enable pulse is high exactly in the first cycle of a stage. A stage
  // may still be holding completed from the previous instruction, so its
  // completed input is masked during that pulse cycle.
  assign w_cur_stage   = stage_onehot(state_q);
  assign w_first_cycle = |en_q;
  assign w_done        = ~w_first_cycle & (|(w_completed & w_cur_stage));
  assign w_is_mem      = is_load | is_store | is_amo;

  assign w_wd_run   = is_stage(state_q);
  assign w_wd_clear = (state_d != state_q);

  seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_watchdog (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (w_wd_clear),
    .run     (w_wd_run),
    .expired (w_wd_expired)
  );

  // Next-state logic: stage sequencing, with watchdog escalation last so
  // that a completion in the limit cycle takes precedence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!halt_req && start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (w_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (w_done) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (w_done) begin
          if (exception) begin
            state_d = S_TRAP;
          end else if (w_is_mem) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_MEM: begin
        if (w_done) state_d = S_WRITE;
      end
      S_WRITE, S_TRAP: begin
        if (w_done) state_d = halt_q ? S_IDLE : S_FETCH;
      end
      S_HUNG: begin
        state_d = S_HUNG;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (w_wd_run && !w_done && w_wd_expired) state_d = S_HUNG;
  end

  // Next values for the enable pulses, halt latch, retire pulse and hang flag.
  always_comb begin
    en_d = (state_d != state_q) ? stage_onehot(state_d) : '0;

    halt_d = halt_q;
    if ((state_q != S_IDLE) && halt_req) halt_d = 1'b1;
    if (state_d == S_IDLE) halt_d = 1'b0;

    retired_d = w_done & ((state_q == S_WRITE) | (state_q == S_TRAP));
    hang_d    = hang_q | ((state_d == S_HUNG) & (state_q != S_HUNG));
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      en_q      <= '0;
      halt_q    <= 1'b0;
      retired_q <= 1'b0;
      hang_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      halt_q    <= halt_d;
      retired_q <= retired_d;
      hang_q    <= hang_d;
    end
  end

  assign fetch_enabled  = en_q[STG_FETCH];
  assign decode_enabled = en_q[STG_DECODE];
  assign exec_enabled   = en_q[STG_EXEC];
  assign mem_enabled    = en_q[STG_MEM];
  assign write_enabled  = en_q[STG_WRITE];
  assign trap_enabled   = en_q[STG_TRAP];
  assign busy           = (state_q != S_IDLE);
  assign retired        = retired_q;
  assign hang_err       = hang_q;

`ifdef SEQ_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instret_cnt_q, instret_cnt_d;

  // Cycles are counted while working (hung time excluded); both wrap.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if ((state_q != S_IDLE) && (state_q != S_HUNG)) cycle_cnt_d = cycle_cnt_q + 64'd1;
    if (retired_q) instret_cnt_d = instret_cnt_q + 64'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = 64'b0;
  assign instret_cnt = 64'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sequencer
// Description : Self-checking bench for core_sequencer. A cycle-level table
//               of {inputs, expected outputs} is built from an
//               instruction-level model (stage list, per-stage latency, halt
//               point), then applied and compared row by row.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

  localparam int unsigned TO = 8;
  localparam int unsigned TW = 4;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic start, halt_req;
  logic fetch_enabled, decode_enabled, exec_enabled, mem_enabled, write_enabled, trap_enabled;
  logic fetch_completed, decode_completed, exec_completed, mem_completed, write_completed, trap_completed;
  logic is_load, is_store, is_amo, exception;
  logic busy, retired, hang_err;
  logic [63:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  core_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (TW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .halt_req         (halt_req),
    .fetch_enabled    (fetch_enabled),
    .fetch_completed  (fetch_completed),
    .decode_enabled   (decode_enabled),
    .decode_completed (decode_completed),
    .exec_enabled     (exec_enabled),
    .exec_completed   (exec_completed),
    .mem_enabled      (mem_enabled),
    .mem_completed    (mem_completed),
    .write_enabled    (write_enabled),
    .write_completed  (write_completed),
    .trap_enabled     (trap_enabled),
    .trap_completed   (trap_completed),
    .is_load          (is_load),
    .is_store         (is_store),
    .is_amo           (is_amo),
    .exception        (exception),
    .busy             (busy),
    .retired          (retired),
    .hang_err         (hang_err),
    .cycle_cnt        (cycle_cnt),
    .instret_cnt      (instret_cnt)
  );

  // Stage lanes: 0 fetch, 1 decode, 2 exec, 3 mem, 4 write, 5 trap.
  // flags: {exception, is_amo, is_store, is_load}.
  typedef struct {
    logic        rst;
    logic        start;
    logic        halt;
    logic [5:0]  comp;
    logic [3:0]  flags;
    logic [5:0]  en;
    logic        busy;
    logic        ret;
    logic        hang;
    logic [63:0] cyc;
    logic [63:0] ins;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model bookkeeping
  bit              ret_pend = 1'b0;
  longint unsigned cyc_acc  = 0;
  longint unsigned ins_acc  = 0;
  int              instr_cyc = 0;
  int              halt_at   = -1;

  function automatic void push(input logic rst, input logic st, input logic hlt,
                               input logic [5:0] comp, input logic [3:0] flags,
                               input logic [5:0] en, input logic bsy, input logic hng);
    vec_t v;
    v.rst = rst; v.start = st; v.halt = hlt; v.comp = comp; v.flags = flags;
    v.en = en; v.busy = bsy; v.hang = hng;
    v.ret = ret_pend;
    ret_pend = 1'b0;
    v.cyc = PERF ? 64'(cyc_acc) : 64'd0;
    v.ins = PERF ? 64'(ins_acc) : 64'd0;
    if (bsy && !hng) cyc_acc++;
    if (v.ret) ins_acc++;
    if (rst) begin
      cyc_acc = 0; ins_acc = 0; ret_pend = 1'b0;
    end
    vq.push_back(v);
  endfunction

  function automatic void gen_idle(input int n);
    for (int i = 0; i < n; i++)
      push(1'b0, 1'b0, 1'($urandom), 6'($urandom), 4'($urandom), 6'd0, 1'b0, 1'b0);
  endfunction

  // start together with halt must be ignored; start alone launches fetch.
  function automatic void gen_start();
    push(1'b0, 1'b1, 1'b1, 6'($urandom), 4'($urandom), 6'd0, 1'b0, 1'b0);
    push(1'b0, 1'b1, 1'b0, 6'($urandom), 4'($urandom), 6'd0, 1'b0, 1'b0);
  endfunction

  // One stage: completes lat cycles after its enable (stage lasts lat+1).
  function automatic void gen_stage(input int s, input int lat, input bit hold, input logic [3:0] xf);
    for (int i = 0; i <= lat; i++) begin
      logic [5:0] c;
      logic [3:0] f;
      logic [5:0] e;
      c = hold ? 6'h3F : 6'($urandom);
      if (!hold && i > 0) c[s] = (i == lat);
      f = (s == 2 && i == lat) ? xf : 4'($urandom);
      e = (i == 0) ? (6'd1 << s) : 6'd0;
      push(1'b0, 1'($urandom), (instr_cyc == halt_at), c, f, e, 1'b1, 1'b0);
      instr_cyc++;
    end
  endfunction

  // kind: 0 alu, 1 load, 2 store, 3 amo, 4 exception.
  // halt_pos: -1 none, -2 random point before the final done, else fixed cycle.
  // base_lat/mem_lat: 0 means random.
  function automatic bit gen_instr(input int kind, input bit hold, input int halt_pos,
                                   input int base_lat, input int mem_lat);
    int st[$];
    int lt[$];
    int total;
    logic [3:0] xf;
    st = '{0, 1, 2};
    case (kind)
      1: xf = 4'b0001;
      2: xf = 4'b0010;
      3: xf = 4'b0100;
      4: xf = {1'b1, 3'($urandom)};
      default: xf = 4'b0000;
    endcase
    if (kind == 4) st.push_back(5);
    else if (kind >= 1) begin st.push_back(3); st.push_back(4); end
    else st.push_back(4);
    total = 0;
    foreach (st[k]) begin
      int l;
      if (hold) l = 1;
      else if (st[k] == 3 && mem_lat > 0) l = mem_lat;
      else if (base_lat > 0) l = base_lat;
      else if ($urandom_range(0, 4) == 0) l = int'(TO) - 1;
      else l = int'($urandom_range(1, 3));
      lt.push_back(l);
      total += l + 1;
    end
    halt_at   = (halt_pos == -2) ? int'($urandom_range(0, total - 2)) : halt_pos;
    instr_cyc = 0;
    foreach (st[k]) gen_stage(st[k], lt[k], hold, xf);
    ret_pend = 1'b1;
    return (halt_at >= 0);
  endfunction

  task automatic check(input string name, input int idx, input logic [5:0] een, input logic eb,
                       input logic er, input logic eh, input logic [63:0] ec, input logic [63:0] ei);
    logic [5:0] aen;
    aen = {trap_enabled, write_enabled, mem_enabled, exec_enabled, decode_enabled, fetch_enabled};
    n_vec++;
    if ({aen, busy, retired, hang_err, cycle_cnt, instret_cnt} !== {een, eb, er, eh, ec, ei}) begin
      n_err++;
      $display("FAIL %s #%0d: got en=%b busy=%b ret=%b hang=%b cyc=%0d ins=%0d, want en=%b busy=%b ret=%b hang=%b cyc=%0d ins=%0d",
               name, idx, aen, busy, retired, hang_err, cycle_cnt, instret_cnt, een, eb, er, eh, ec, ei);
    end
  endtask

  task automatic drive(input vec_t v);
    rstn             = ~v.rst;
    start            = v.start;
    halt_req         = v.halt;
    fetch_completed  = v.comp[0];
    decode_completed = v.comp[1];
    exec_completed   = v.comp[2];
    mem_completed    = v.comp[3];
    write_completed  = v.comp[4];
    trap_completed   = v.comp[5];
    is_load          = v.flags[0];
    is_store         = v.flags[1];
    is_amo           = v.flags[2];
    exception        = v.flags[3];
  endtask

  initial begin
    vec_t z;
    bit   h;
    z = '{rst: 1'b1, start: 1'b0, halt: 1'b0, comp: 6'd0, flags: 4'd0, en: 6'd0,
          busy: 1'b0, ret: 1'b0, hang: 1'b0, cyc: 64'd0, ins: 64'd0};
    drive(z);

    // Halt during EXEC of a single ALU instruction (1-cycle stage latency).
    gen_idle(2);
    gen_start();
    void'(gen_instr(0, 1'b0, 4, 1, 0));
    gen_idle(3);

    // ALU, load with slow mem, exception, completed held high everywhere.
    gen_start();
    void'(gen_instr(0, 1'b0, -1, 1, 0));
    void'(gen_instr(1, 1'b0, -1, 1, 3));
    void'(gen_instr(4, 1'b0, -1, 1, 0));
    void'(gen_instr(3, 1'b1, -1, 1, 0));
    void'(gen_instr(4, 1'b1, -1, 1, 0));

    // Random instruction mix with occasional halts and restarts.
    for (int n = 0; n < 60; n++) begin
      h = gen_instr(int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 5) == 0) ? -2 : -1, 0, 0);
      if (h) begin
        gen_idle(int'($urandom_range(1, 3)));
        gen_start();
      end
    end
    void'(gen_instr(int'($urandom_range(0, 4)), 1'b0, -2, 0, 0));
    gen_idle(2);

    // Decode never completes: hang after TO decode cycles, then reset.
    gen_start();
    halt_at = -1; instr_cyc = 0;
    gen_stage(0, 1, 1'b0, 4'd0);
    for (int i = 0; i < int'(TO); i++) begin
      logic [5:0] c;
      c = 6'($urandom);
      if (i > 0) c[1] = 1'b0;
      push(1'b0, 1'($urandom), 1'b0, c, 4'($urandom), (i == 0) ? 6'd2 : 6'd0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++)
      push(1'b0, 1'($urandom), 1'($urandom), (i == 0) ? 6'h3F : 6'($urandom), 4'($urandom),
           6'd0, 1'b1, 1'b1);
    push(1'b1, 1'b0, 1'b0, 6'd0, 4'd0, 6'd0, 1'b1, 1'b1);
    gen_idle(2);
    gen_start();
    void'(gen_instr(1, 1'b0, -2, 0, 0));
    gen_idle(2);

    // Apply: compare the outputs of each cycle at the negedge, then drive.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", -1, 6'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    z.rst = 1'b0;
    drive(z);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      check("vec", i, vq[i].en, vq[i].busy, vq[i].ret, vq[i].hang, vq[i].cyc, vq[i].ins);
      drive(vq[i]);
      if (vq[i].rst) begin
        #1;
        check("async_reset", i, 6'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
